// File: rtl/gain_multiplier.sv
// gain_multiplier: scales a 16-bit word by an unsigned fixed-point gain using a
// sequential shift-add multiplier, saturating the result to 16 bits. Talks to
// the memory block through a level-based four-phase data_rdy/result_rdy handshake.
`timescale 1ns/1ps

module gain_multiplier #(
    parameter int FRAC_BITS = 8,
    parameter int WIDTH     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data,
    input  logic             data_rdy,
    input  logic [WIDTH-1:0] gain,
    output logic [WIDTH-1:0] result,
    output logic             result_rdy,
    output logic             sat,
    output logic             busy
);

    localparam int ACC_W = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH) + 1;
    // The last MUL edge is the one that moves the counter from WIDTH-1 to WIDTH.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        SAT,
        WAIT_LOW
    } state_t;

    state_t state;
    state_t next_state;

    logic [ACC_W-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] shifted;
    logic             saturate;

    // State register; reset wins over any in-flight multiply.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and busy flag from the current state and handshake level.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (data_rdy) begin
                    next_state = MUL;
                end
            end
            MUL: begin
                busy = 1'b1;
                if (cnt == LAST_CNT) begin
                    next_state = SAT;
                end
            end
            SAT: begin
                busy       = 1'b1;
                next_state = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!data_rdy) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Drop the fractional bits (truncation) and flag anything that exceeds 16 bits.
    always_comb begin
        shifted  = acc >> FRAC_BITS;
        saturate = |shifted[ACC_W-1:WIDTH];
    end

    // Datapath: operand capture, one multiplier bit per MUL cycle, then the
    // saturated result and completion level held until data_rdy drops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand      <= '0;
            mplier     <= '0;
            acc        <= '0;
            cnt        <= '0;
            result     <= '0;
            result_rdy <= 1'b0;
            sat        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_rdy) begin
                        mcand  <= {{WIDTH{1'b0}}, gain};
                        mplier <= data;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                MUL: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                end
                SAT: begin
                    if (saturate) begin
                        result <= '1;
                        sat    <= 1'b1;
                    end else begin
                        result <= shifted[WIDTH-1:0];
                        sat    <= 1'b0;
                    end
                    result_rdy <= 1'b1;
                end
                WAIT_LOW: begin
                    if (!data_rdy) begin
                        result_rdy <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gain_multiplier.sv
// tb_gain_multiplier: directed vectors for gain_multiplier, checked every cycle
// against a transaction-level model plus hand-computed literal results.
`timescale 1ns/1ps

module tb_gain_multiplier;

    localparam int FRAC = 8;
    localparam int LAT  = 17;

    logic        clk;
    logic        rst_n;
    logic [15:0] data;
    logic        data_rdy;
    logic [15:0] gain;
    logic [15:0] result;
    logic        result_rdy;
    logic        sat;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: a countdown to completion instead of any state encoding.
    int          m_left   = 0;
    bit          m_hold   = 1'b0;
    logic [15:0] m_result = '0;
    logic        m_sat    = 1'b0;
    logic        m_rdy    = 1'b0;
    logic [15:0] cap_data = '0;
    logic [15:0] cap_gain = '0;
    bit          check_en = 1'b0;

    gain_multiplier #(.FRAC_BITS(FRAC), .WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data       (data),
        .data_rdy   (data_rdy),
        .gain       (gain),
        .result     (result),
        .result_rdy (result_rdy),
        .sat        (sat),
        .busy       (busy)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Golden arithmetic: {sat, min((d*g)>>FRAC, 16'hFFFF)}.
    function automatic logic [16:0] golden(input logic [15:0] d, input logic [15:0] g);
        logic [31:0] p;
        p = (32'(d) * 32'(g)) >> FRAC;
        if (p > 32'h0000_FFFF) return {1'b1, 16'hFFFF};
        return {1'b0, p[15:0]};
    endfunction

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, want %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Pin both the DUT and the model to a hand-computed result.
    task automatic check_output(input string name, input logic [15:0] exp_res, input logic exp_sat);
        check_val({name, "_result"}, result, exp_res);
        check_val({name, "_sat"}, sat, exp_sat);
        check_val({name, "_model_result"}, m_result, exp_res);
        check_val({name, "_model_sat"}, m_sat, exp_sat);
    endtask

    // Behavioural model: request seen in idle starts a 17-edge countdown,
    // completion raises result_rdy until data_rdy is seen low.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_left   = 0;
            m_hold   = 1'b0;
            m_result = '0;
            m_sat    = 1'b0;
            m_rdy    = 1'b0;
            check_en = 1'b1;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                {m_sat, m_result} = golden(cap_data, cap_gain);
                m_rdy  = 1'b1;
                m_hold = 1'b1;
            end
        end else if (m_hold) begin
            if (!data_rdy) begin
                m_rdy  = 1'b0;
                m_hold = 1'b0;
            end
        end else if (data_rdy) begin
            cap_data = data;
            cap_gain = gain;
            m_left   = LAT;
        end
    end

    // Cycle-by-cycle compare on the falling edge once reset has been seen.
    always @(negedge clk) begin
        if (check_en) begin
            check_val("cyc_result", result, m_result);
            check_val("cyc_sat", sat, m_sat);
            check_val("cyc_result_rdy", result_rdy, m_rdy);
            check_val("cyc_busy", busy, (m_left > 0));
        end
    end

    // Raise a request and wait (bounded) for result_rdy; reports edges and busy cycles.
    task automatic apply_stimulus(input logic [15:0] d, input logic [15:0] g,
                                  output int lat, output int busy_cycles);
        @(negedge clk);
        data     = d;
        gain     = g;
        data_rdy = 1'b1;
        @(posedge clk);
        #1;
        lat         = 0;
        busy_cycles = busy ? 1 : 0;
        while (result_rdy !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) busy_cycles++;
        end
        if (result_rdy !== 1'b1) check_val("rdy_timeout", {31'b0, result_rdy}, 32'd1);
    endtask

    // Drop data_rdy and confirm result_rdy falls on the next edge with result held.
    task automatic release_request(input logic [15:0] keep);
        @(negedge clk);
        data_rdy = 1'b0;
        @(posedge clk);
        #1;
        check_val("rdy_fall", result_rdy, 0);
        check_val("result_hold", result, keep);
    endtask

    logic [15:0] b2b_data [3] = '{16'h4000, 16'h0ABC, 16'hFFFF};
    logic [15:0] b2b_gain [3] = '{16'h0500, 16'h0133, 16'h00FF};
    logic [15:0] b2b_res  [3] = '{16'hFFFF, 16'h0CDF, 16'hFEFF};
    logic        b2b_sat  [3] = '{1'b1, 1'b0, 1'b0};

    initial begin
        int lat;
        int bc;
        int pulse;

        rst_n    = 1'b0;
        data     = '0;
        gain     = '0;
        data_rdy = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_result", result, 0);
        check_val("reset_rdy", result_rdy, 0);
        check_val("reset_sat", sat, 0);
        check_val("reset_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Scaling case: 1.0 * 1.5 in Q8.8.
        apply_stimulus(16'h0100, 16'h0180, lat, bc);
        check_val("scale_latency", lat, LAT);
        check_val("scale_busy_cycles", bc, LAT);
        check_output("scale", 16'h0180, 1'b0);
        release_request(16'h0180);

        // Unity gain with data_rdy held high: no recompute.
        apply_stimulus(16'h1234, 16'h0100, lat, bc);
        check_output("unity", 16'h1234, 1'b0);
        repeat (10) begin
            @(posedge clk);
            #1;
            check_val("unity_hold_rdy", result_rdy, 1);
            check_val("unity_hold_busy", busy, 0);
        end
        release_request(16'h1234);

        // Saturation, truncation, zero.
        apply_stimulus(16'hFFFF, 16'h0200, lat, bc);
        check_output("saturate", 16'hFFFF, 1'b1);
        release_request(16'hFFFF);
        apply_stimulus(16'h0003, 16'h0080, lat, bc);
        check_output("truncate", 16'h0001, 1'b0);
        release_request(16'h0001);
        apply_stimulus(16'h0000, 16'h0080, lat, bc);
        check_output("zero", 16'h0000, 1'b0);
        release_request(16'h0000);

        // Operand stability and early data_rdy drop.
        @(negedge clk);
        data     = 16'h0010;
        gain     = 16'h0300;
        data_rdy = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        @(negedge clk);
        data = 16'hFFFF;
        gain = 16'hFFFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        data_rdy = 1'b0;
        lat = 8;
        #1;
        while (result_rdy !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_val("stable_latency", lat, LAT);
        check_output("stable", 16'h0030, 1'b0);
        pulse = 0;
        repeat (3) begin
            if (result_rdy) pulse++;
            @(posedge clk);
            #1;
        end
        check_val("stable_pulse_width", pulse, 1);
        check_val("stable_idle_busy", busy, 0);

        // Reset in the middle of a multiply, request still pending afterwards.
        @(negedge clk);
        data     = 16'h0200;
        gain     = 16'h0123;
        data_rdy = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_val("midrst_result", result, 0);
        check_val("midrst_rdy", result_rdy, 0);
        check_val("midrst_sat", sat, 0);
        check_val("midrst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        lat = 0;
        #1;
        while (result_rdy !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_val("midrst_latency", lat, LAT);
        check_output("midrst", 16'h0246, 1'b0);
        release_request(16'h0246);

        // Back-to-back requests with a single low cycle between them.
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(b2b_data[i], b2b_gain[i], lat, bc);
            check_val("b2b_latency", lat, LAT);
            check_output("b2b", b2b_res[i], b2b_sat[i]);
            release_request(b2b_res[i]);
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] time limit reached");
    end

endmodule

// File: doc/gain_multiplier.md
Name: gain_multiplier

Overview:
- Multiplier peripheral at the far end of the CPU memory's multiplier interface.
- Takes the 16-bit `data` word and `data_rdy` flag written by 6502 software through memory-mapped IO.
- Scales the word by a fixed-point gain using a sequential shift-add multiplier.
- Returns `result` and `result_rdy`, which the memory block mirrors back into RAM for software to poll. The handshake is four-phase and level-based.

Parameters:
- FRAC_BITS, 8: number of fractional bits in `gain`. The result is `(data*gain) >> FRAC_BITS`.
- WIDTH, 16: operand and result width. 16 is the only supported value.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- data  input  16  unsigned operand from the memory block.
- data_rdy  input  1  request level from the memory block. Only bit 0 of the RAM byte is used.
- gain  input  16  unsigned gain, Q(16-FRAC_BITS).FRAC_BITS. Sampled at capture.
- result  output  16  scaled, saturated product. Registered.
- result_rdy  output  1  completion level to the memory block.
- sat  output  1  set when the current result was clipped. Registered with `result`.
- busy  output  1  high in MUL and SAT.

Behaviour:
- Reset: when `rst_n`=0 at a rising edge, the block goes to state IDLE and clears `result`, `result_rdy`, `sat`, the accumulator and the counter. Reset overrides everything, including mid-operation; the partial product is discarded.
- State IDLE:
  - If `data_rdy`=1, latch `mcand`={16'h0,`gain`} (32 bits) and `mplier`=`data`, clear `acc` (32 bits) and `cnt` (5 bits), then go to MUL.
  - Otherwise stay in IDLE.
- State MUL, one bit per clock:
  - If `mplier[0]`, `acc`<=`acc`+`mcand`.
  - `mcand`<<=1; `mplier`>>=1; `cnt`++.
  - After the 16th MUL edge (`cnt` reaches 16), go to SAT.
- State SAT:
  - Compute `shifted` = `acc` >> FRAC_BITS, truncating with no rounding.
  - If `shifted` > 16'hFFFF: `result`<=16'hFFFF and `sat`<=1.
  - Otherwise: `result`<=`shifted[15:0]` and `sat`<=0.
  - `result_rdy`<=1; go to WAIT_LOW.
- State WAIT_LOW:
  - Hold `result`, `sat` and `result_rdy`=1 while `data_rdy`=1.
  - When `data_rdy`=0, `result_rdy`<=0 and go to IDLE.
- Latency: capture edge N; MUL edges N+1..N+16; SAT edge N+17. `result` and `result_rdy` are valid after edge N+17.
- `result` and `sat` keep their values after `result_rdy` falls, until the next SAT edge.
- Operands are latched at capture. Changes on `data` or `gain` during MUL, SAT or WAIT_LOW have no effect.
- If `data_rdy` falls during MUL or SAT, the computation still completes. WAIT_LOW then clears `result_rdy` on the next edge, giving a one-cycle `result_rdy` pulse.
- If `data_rdy` stays high after completion, nothing retriggers. A new request requires `data_rdy` to be seen low, which returns the block to IDLE, and then seen high again.
- `data_rdy`=1 at the same edge that reset is released has no effect; capture can happen no earlier than the following edge.
- `busy`=1 exactly in states MUL and SAT.
- Arithmetic: the 32-bit accumulator cannot overflow for 16x16 operands. Saturation applies only to the 16-bit output.

Test Plan:
- Scaling case: rst_n low 2 cycles then high; `data`=16'h0100, `gain`=16'h0180, `data_rdy`=1 → `result_rdy` rises exactly 17 cycles after the capture edge, `result`=16'h0180, `sat`=0, `busy` high for 17 cycles.
- Unity gain: `data`=16'h1234, `gain`=16'h0100 → `result`=16'h1234, `sat`=0. Hold `data_rdy`=1 for 10 further cycles → `result_rdy` stays 1 and no recompute occurs. Drop `data_rdy` → `result_rdy`=0 next edge, `result` still 16'h1234.
- Saturation and truncation:
  - `data`=16'hFFFF, `gain`=16'h0200 → `result`=16'hFFFF, `sat`=1.
  - Then `data`=16'h0003, `gain`=16'h0080 → `result`=16'h0001 (truncated from 1.5), `sat`=0.
  - Then `data`=16'h0000 → `result`=0.
- Operand stability: capture `data`=16'h0010, `gain`=16'h0300. Change `data` to 16'hFFFF at MUL cycle 5 and drop `data_rdy` at MUL cycle 8 → `result`=16'h0030, one-cycle `result_rdy` pulse, block returns to IDLE.
- Reset mid-operation: assert `rst_n`=0 for 1 cycle at MUL cycle 9 → next edge `result`=0, `result_rdy`=0, `sat`=0, `busy`=0. With `data_rdy` still 1 after release → fresh capture and correct result 17 cycles later.
- Back-to-back requests: toggle `data_rdy` 1→0→1 with minimal gaps over 3 operand pairs → each result matches a golden model of `min((data*gain)>>8, 16'hFFFF)`, and there is no `result_rdy` overlap across transactions.
